// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STALL,
        S_DROP
    } state_t;

    // Instruction captured while decode is stalled.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } hold_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack handshake bundle.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
    import fetch_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [XLEN-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/npc_sel.sv
// Next-PC redirect priority (jalr > jal > br) and target adder.
module npc_sel
    import fetch_pkg::*;
(
    input  logic            br_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] RegFD_PC,
    input  logic [XLEN-1:0] jalr_PC,
    output logic            redirect,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        redirect   = jalr_en | jal_en | br_en;
        raw_target = jalr_en ? jalr_PC : (RegFD_PC + imm);
        target     = raw_target & ~XLEN'(3);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake and
// loads the fetch/decode register, with redirect, stall and drop handling.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     ADDR_W    = 17,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_en,
    input  logic              jal_en,
    input  logic              jalr_en,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   RegFD_PC,
    input  logic [XLEN-1:0]   jalr_PC,
    fetch_ctrl_if.master      mem,
    output logic              fd_valid,
    output logic [XLEN-1:0]   fd_instr,
    output logic [XLEN-1:0]   fd_pc,
    output logic [XLEN-1:0]   fd_npc,
    output logic              flush
);

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n, pc_inc;
    logic              req_q, req_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              fd_valid_n;
    logic [XLEN-1:0]   fd_instr_n, fd_pc_n, fd_npc_n;
    logic              flush_n;
    hold_t             hold, hold_n;
    logic              hold_vld, hold_vld_n;
    logic              redirect, take_redirect;
    logic [XLEN-1:0]   target;
    logic              ack;

    npc_sel u_npc_sel (
        .br_en    (br_en),
        .jal_en   (jal_en),
        .jalr_en  (jalr_en),
        .imm      (imm),
        .RegFD_PC (RegFD_PC),
        .jalr_PC  (jalr_PC),
        .redirect (redirect),
        .target   (target)
    );

    assign mem.imem_req  = req_q;
    assign mem.imem_addr = addr_q;
    assign ack           = mem.imem_ack;
    assign pc_inc        = pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC[ADDR_W+1:2];
            fd_valid <= 1'b0;
            fd_instr <= NOP_INSTR;
            fd_pc    <= RESET_PC;
            fd_npc   <= RESET_PC + XLEN'(4);
            flush    <= 1'b0;
            hold     <= '0;
            hold_vld <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            fd_valid <= fd_valid_n;
            fd_instr <= fd_instr_n;
            fd_pc    <= fd_pc_n;
            fd_npc   <= fd_npc_n;
            flush    <= flush_n;
            hold     <= hold_n;
            hold_vld <= hold_vld_n;
        end
    end

    // Next-state and next-register values; the address register only moves
    // when a fresh request is launched, keeping it stable until ack.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_n      = req_q;
        addr_n     = addr_q;
        fd_valid_n = fd_valid;
        fd_instr_n = fd_instr;
        fd_pc_n    = fd_pc;
        fd_npc_n   = fd_npc;
        flush_n    = 1'b0;
        hold_n     = hold;
        hold_vld_n = hold_vld;

        take_redirect = redirect && (state != S_IDLE);
        if (take_redirect) begin
            pc_n       = target;
            flush_n    = 1'b1;
            fd_valid_n = 1'b0;
            fd_instr_n = NOP_INSTR;
            hold_vld_n = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                state_n = S_REQ;
                req_n   = 1'b1;
                addr_n  = pc[ADDR_W+1:2];
            end
            S_REQ: begin
                if (take_redirect) begin
                    if (ack) addr_n  = target[ADDR_W+1:2];
                    else     state_n = S_DROP;
                end else if (ack && stall) begin
                    hold_n     = '{instr: mem.imem_rdata, pc: pc};
                    hold_vld_n = 1'b1;
                    pc_n       = pc_inc;
                    req_n      = 1'b0;
                    state_n    = S_STALL;
                end else if (ack) begin
                    fd_instr_n = mem.imem_rdata;
                    fd_pc_n    = pc;
                    fd_npc_n   = pc_inc;
                    fd_valid_n = 1'b1;
                    pc_n       = pc_inc;
                    addr_n     = pc_inc[ADDR_W+1:2];
                end
            end
            S_STALL: begin
                if (take_redirect) begin
                    state_n = S_REQ;
                    req_n   = 1'b1;
                    addr_n  = target[ADDR_W+1:2];
                end else if (!stall) begin
                    fd_instr_n = hold.instr;
                    fd_pc_n    = hold.pc;
                    fd_npc_n   = hold.pc + XLEN'(4);
                    fd_valid_n = 1'b1;
                    hold_vld_n = 1'b0;
                    state_n    = S_REQ;
                    req_n      = 1'b1;
                    addr_n     = pc[ADDR_W+1:2];
                end
            end
            S_DROP: begin
                // Stale data is discarded; pc_n already carries any new target.
                if (ack) begin
                    state_n = S_REQ;
                    addr_n  = pc_n[ADDR_W+1:2];
                end
            end
            default: begin
                state_n = S_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: one cycle per vector, outputs checked
// 1 time unit after the rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, br_en, jal_en, jalr_en;
    logic [31:0] imm, RegFD_PC, jalr_PC;
    logic        fd_valid, flush;
    logic [31:0] fd_instr, fd_pc, fd_npc;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_ctrl_if #(.ADDR_W(17)) mem ();

    fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(17), .NOP_INSTR(32'h13)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .br_en    (br_en),
        .jal_en   (jal_en),
        .jalr_en  (jalr_en),
        .imm      (imm),
        .RegFD_PC (RegFD_PC),
        .jalr_PC  (jalr_PC),
        .mem      (mem),
        .fd_valid (fd_valid),
        .fd_instr (fd_instr),
        .fd_pc    (fd_pc),
        .fd_npc   (fd_npc),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    // ctl bits: {rst, stall, br_en, jal_en, jalr_en}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] imm, fdpc, jpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, fpc;
        logic        flush;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] imm_v,
                                input logic [31:0] fdpc, input logic [31:0] jpc,
                                input logic ack, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] instr,
                                input logic [31:0] fpc, input logic fl);
        vec_t v;
        v.ctl = ctl; v.imm = imm_v; v.fdpc = fdpc; v.jpc = jpc;
        v.ack = ack; v.rdata = rdata; v.req = req; v.addr = addr;
        v.valid = valid; v.instr = instr; v.fpc = fpc; v.flush = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        {rst, stall, br_en, jal_en, jalr_en} = v.ctl;
        imm = v.imm; RegFD_PC = v.fdpc; jalr_PC = v.jpc;
        mem.imem_ack = v.ack; mem.imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        n_vec++;
        chk({tag, ".req"},   32'(mem.imem_req),  32'(v.req));
        chk({tag, ".addr"},  32'(mem.imem_addr), v.addr);
        chk({tag, ".valid"}, 32'(fd_valid),      32'(v.valid));
        chk({tag, ".instr"}, fd_instr,           v.instr);
        chk({tag, ".pc"},    fd_pc,              v.fpc);
        chk({tag, ".npc"},   fd_npc,             v.fpc + 32'd4);
        chk({tag, ".flush"}, 32'(flush),         32'(v.flush));
    endtask

    initial begin
        {rst, stall, br_en, jal_en, jalr_en} = 5'b10000;
        imm = '0; RegFD_PC = '0; jalr_PC = '0;
        mem.imem_ack = 1'b0; mem.imem_rdata = '0;

        // reset, then sequential fetch with zero-latency memory
        vq.push_back(mk(5'b10000, 0, 0, 0, 0, 0,            0, 32'h0,   0, 32'h13,       32'h0,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h0,   0, 32'h13,       32'h0,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000000, 1, 32'h1,   1, 32'hA0000000, 32'h0,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000001, 1, 32'h2,   1, 32'hA0000001, 32'h4,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000002, 1, 32'h3,   1, 32'hA0000002, 32'h8,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000003, 1, 32'h4,   1, 32'hA0000003, 32'hC,    0));
        // stall while ack returns at pc 0x10
        vq.push_back(mk(5'b01000, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h4,   1, 32'hA0000003, 32'hC,    0));
        vq.push_back(mk(5'b01000, 0, 0, 0, 0, 0,            0, 32'h4,   1, 32'hA0000003, 32'hC,    0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h5,   1, 32'hDEADBEEF, 32'h10,   0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000005, 1, 32'h6,   1, 32'hA0000005, 32'h14,   0));
        // branch 0x100 - 8 with same-cycle ack
        vq.push_back(mk(5'b00100, 32'hFFFFFFF8, 32'h100, 0, 1, 32'hA0000006, 1, 32'h3E, 0, 32'h13, 32'h14, 1));
        vq.push_back(mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h3E,  0, 32'h13,       32'h14,   0));
        // all three redirects, no ack: jalr wins, drop outstanding request
        vq.push_back(mk(5'b00111, 32'h40, 32'h100, 32'h2003, 0, 0, 1, 32'h3E, 0, 32'h13,    32'h14,   1));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 32'h800, 0, 32'h13,       32'h14,   0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000800, 1, 32'h801, 1, 32'hA0000800, 32'h2000, 0));
        // 3-cycle ack latency, jal to 0x40 in wait cycle 1
        vq.push_back(mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h801, 1, 32'hA0000800, 32'h2000, 0));
        vq.push_back(mk(5'b00010, 32'h10, 32'h30, 0, 0, 0,  1, 32'h801, 0, 32'h13,       32'h2000, 1));
        vq.push_back(mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h801, 0, 32'h13,       32'h2000, 0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hBAD1BAD1, 1, 32'h10,  0, 32'h13,       32'h2000, 0));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000010, 1, 32'h11,  1, 32'hA0000010, 32'h40,   0));
        // two redirects while dropping: latest target wins
        vq.push_back(mk(5'b00001, 0, 0, 32'h80,  0, 0,      1, 32'h11,  0, 32'h13,       32'h40,   1));
        vq.push_back(mk(5'b00001, 0, 0, 32'h204, 0, 0,      1, 32'h11,  0, 32'h13,       32'h40,   1));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hBAD2BAD2, 1, 32'h81,  0, 32'h13,       32'h40,   0));
        // branch target wraps past 2^32
        vq.push_back(mk(5'b00100, 32'h8, 32'hFFFFFFFC, 0, 1, 32'hA0000081, 1, 32'h1, 0, 32'h13, 32'h40, 1));
        // stall without ack keeps request, then stall with ack, then redirect from S_STALL
        vq.push_back(mk(5'b01000, 0, 0, 0, 0, 0,            1, 32'h1,   0, 32'h13,       32'h40,   0));
        vq.push_back(mk(5'b01000, 0, 0, 0, 1, 32'hCAFE0004, 0, 32'h1,   0, 32'h13,       32'h40,   0));
        vq.push_back(mk(5'b01100, 0, 32'h1000, 0, 0, 0,     1, 32'h400, 0, 32'h13,       32'h40,   1));
        vq.push_back(mk(5'b00000, 0, 0, 0, 1, 32'hA0000400, 1, 32'h401, 1, 32'hA0000400, 32'h1000, 0));

        for (int i = 0; i < vq.size(); i++)
            apply($sformatf("v%0d", i), vq[i]);

        // reset arriving while a dropped request is outstanding, ack in reset cycle ignored
        apply("rd0", mk(5'b00010, 32'h100, 32'h500, 0, 0, 0, 1, 32'h401, 0, 32'h13, 32'h1000, 1));
        apply("rd1", mk(5'b00000, 0, 0, 0, 0, 0,            1, 32'h401, 0, 32'h13,       32'h1000, 0));
        apply("rd2", mk(5'b10000, 0, 0, 0, 1, 32'hBAD3BAD3, 0, 32'h0,   0, 32'h13,       32'h0,    0));
        // redirect in S_IDLE is ignored
        apply("rd3", mk(5'b00100, 0, 32'h100, 0, 0, 0,      1, 32'h0,   0, 32'h13,       32'h0,    0));
        apply("rd4", mk(5'b00000, 0, 0, 0, 1, 32'hA0000000, 1, 32'h1,   1, 32'hA0000000, 32'h0,    0));
        apply("rd5", mk(5'b00000, 0, 0, 0, 1, 32'hA0000001, 1, 32'h2,   1, 32'hA0000001, 32'h4,    0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage.
- Owns the architectural PC and runs a req/ack handshake to instruction memory.
- Arbitrates next-PC sources (jalr, jal, branch, stall, sequential) and delivers fetched instructions to the fetch/decode pipeline register.
- Sits between the hazard/branch logic in decode/execute and the instruction memory. It replaces ad-hoc PC muxing with a single registered controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 17, width of the imem word address.
- NOP_INSTR, 32'h0000_0013, instruction injected on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold the PC and the FD outputs.
- br_en  in  1  taken branch resolved; target = RegFD_PC + imm.
- jal_en  in  1  jal; target = RegFD_PC + imm.
- jalr_en  in  1  jalr; target = jalr_PC.
- imm  in  32  signed offset for br/jal.
- RegFD_PC  in  32  PC of the instruction currently in decode.
- jalr_PC  in  32  computed jalr target.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2].
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched instruction, valid when imem_ack is high.
- fd_valid  out  1  FD register holds a real instruction.
- fd_instr  out  32  instruction to decode.
- fd_pc  out  32  PC of fd_instr.
- fd_npc  out  32  fd_pc + 4.
- flush  out  1  one-cycle pulse; younger pipeline contents invalid.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = S_IDLE.
  - imem_req = 0; fd_valid = 0; fd_instr = NOP_INSTR; fd_pc = RESET_PC; fd_npc = RESET_PC + 4; flush = 0.
  - Hold buffer is empty.
- Reset asserted in any state, including mid-handshake, aborts immediately. Any ack arriving in the reset cycle is ignored.
- Redirect priority: jalr_en > jal_en > br_en. Redirect beats stall.
- Target arithmetic is 32-bit modulo (wrap-around allowed). Bits [1:0] of the target are forced to 0.
- imem_req is a registered output. While imem_req = 1 and imem_ack = 0, imem_addr must stay stable. The request is never withdrawn before ack.
- States:
  - S_IDLE: imem_req = 0. Go to S_REQ on the next cycle.
  - S_REQ: imem_req = 1, imem_addr from pc.
    - ack, no stall, no redirect: fd_instr <= imem_rdata, fd_pc <= pc, fd_npc <= pc + 4, fd_valid <= 1, pc <= pc + 4. Stay in S_REQ. Back-to-back fetch gives 1 instruction/cycle with a zero-latency memory.
    - ack with stall: write the instruction and its PC into the hold buffer, pc <= pc + 4, FD outputs unchanged. Go to S_STALL.
    - no ack, stall: keep the request. FD outputs unchanged.
  - S_STALL: imem_req = 0. FD outputs held. When stall = 0: move the hold buffer to the FD outputs (fd_valid = 1), empty the buffer, go to S_REQ.
  - S_DROP: request still outstanding to the old address. imem_req = 1, imem_addr = old address. On ack, discard the data and go to S_REQ using the new pc.
- Redirect (any state except S_IDLE):
  - pc <= target; flush = 1 for exactly the next cycle.
  - fd_valid <= 0, fd_instr <= NOP_INSTR. Hold buffer emptied.
  - If a request is outstanding with no ack this cycle: go to S_DROP.
  - If ack is in the same cycle: discard the data and go to S_REQ.
  - From S_STALL: go to S_REQ.
- Redirect while in S_DROP: latest target wins, flush pulses again, stay in S_DROP.
- Simultaneous redirect and stall: redirect processed, stall ignored for that cycle.
- fd_npc is always fd_pc + 4, mod 2^32.

Decomposition:
- Shared package fetch_pkg:
  - state enum S_IDLE, S_REQ, S_STALL, S_DROP.
  - NOP_INSTR, XLEN = 32, default RESET_PC.
- One sub-module, npc_sel: combinational redirect priority and target adder. Outputs redirect and target[31:0].
- FSM, PC register, hold buffer and FD registers live in fetch_ctrl.

Test Plan:
- Sequential fetch: reset, then imem_ack tied high, rdata = addr-tagged words → imem_addr 0, 1, 2…; fd_pc 0x0, 0x4, 0x8 on consecutive cycles; fd_npc = fd_pc + 4.
- Branch: RegFD_PC = 0x100, imm = -8, br_en pulse → next imem_addr = 0x3E (pc 0xF8); flush high one cycle; fd_instr = 0x00000013, fd_valid = 0.
- Redirect priority: jalr_en = jal_en = br_en = 1, jalr_PC = 0x2003 → pc = 0x2000; jal and br targets ignored.
- Stall with ack: stall = 1 while ack returns 0xDEADBEEF at pc 0x10 → FD holds its old value; imem_req drops; after stall = 0, fd_instr = 0xDEADBEEF, fd_pc = 0x10, fetch resumes at 0x14.
- Redirect while waiting: 3-cycle ack latency, jal_en asserted in cycle 1 of the wait (target 0x40) → imem_addr holds the old address until ack, returned data discarded, next request addr = 0x10 (pc 0x40).
- Mid-operation reset: rst asserted during S_DROP → next cycle imem_req = 0, pc = RESET_PC, fd_valid = 0, fetch restarts at 0x0.
